// File: rtl/instr_issue_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_issue_unit                                                |
// | Purpose  : Program store + PC stepper feeding one instruction at a time.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module instr_issue_unit #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_wen,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic                   start,
  input  logic                   instr_done,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   halted,
  output logic                   err_timeout,
  output logic [7:0]             issue_count
);

  localparam int DEPTH = 2**PC_BITS;
  localparam int WD_W  = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] word_q, word_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic                   halted_q, halted_d;
  logic                   err_q, err_d;
  logic [7:0]             count_q, count_d;
  logic [WD_W-1:0]        wd_q, wd_d;

  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
  logic                   w_stopped;
  logic [INSTR_WIDTH-1:0] w_fetch_word;

  assign w_stopped    = (state_q == S_IDLE) || (state_q == S_HALT);
  assign w_fetch_word = mem_q[pc_q];

  // Store is only writable while no run is in progress; never cleared by rst.
  always_ff @(posedge clk) begin
    if (prog_wen && w_stopped) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    word_d   = word_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    err_d    = err_q;
    count_d  = count_q;
    wd_d     = wd_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d  = S_FETCH;
          pc_d     = '0;
          count_d  = '0;
          err_d    = 1'b0;
          halted_d = 1'b0;
        end
      end
      S_FETCH: begin
        word_d = w_fetch_word;
        if (w_fetch_word[INSTR_WIDTH-1 -: 2] == 2'b00) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        instr_d = word_q;
        valid_d = 1'b1;
        wd_d    = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // A retire on the last watchdog cycle takes priority over the timeout.
        if (instr_done) begin
          instr_d = '0;
          valid_d = 1'b0;
          if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
          end
          if (pc_q == {PC_BITS{1'b1}}) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            pc_d    = pc_q + PC_BITS'(1);
            state_d = S_FETCH;
          end
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          instr_d  = '0;
          valid_d  = 1'b0;
          err_d    = 1'b1;
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      word_q   <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      word_q   <= word_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      count_q  <= count_d;
      wd_q     <= wd_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = !w_stopped;
  assign halted      = halted_q;
  assign err_timeout = err_q;
  assign issue_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_issue_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_instr_issue_unit                                             |
// | Purpose  : Directed bench for instr_issue_unit with a run-level model.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_instr_issue_unit;
  localparam int W     = 20;
  localparam int PB    = 4;
  localparam int TO    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_wen = 1'b0;
  logic [PB-1:0] prog_addr = '0;
  logic [W-1:0]  prog_data = '0;
  logic          start = 1'b0;
  logic          instr_done = 1'b0;
  logic [W-1:0]  instr;
  logic          instr_valid;
  logic [PB-1:0] pc;
  logic          busy;
  logic          halted;
  logic          err_timeout;
  logic [7:0]    issue_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [W-1:0] exp_words [DEPTH];

  always #5 clk = ~clk;

  instr_issue_unit #(.INSTR_WIDTH(W), .PC_BITS(PB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .prog_wen(prog_wen), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .instr_done(instr_done),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .busy(busy),
    .halted(halted), .err_timeout(err_timeout), .issue_count(issue_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Run-level model: a run walks the shadow program; each word appears two edges
  // after the run (re)starts, and lives until retired or the watchdog age expires.
  logic [W-1:0] m_prog [DEPTH];
  logic [W-1:0] m_word, m_instr;
  logic         m_valid = 1'b0, m_run = 1'b0, m_halted = 1'b0, m_err = 1'b0;
  int           m_pc = 0, m_cnt = 0, m_gap = 0, m_age = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_run <= 1'b0; m_pc <= 0; m_cnt <= 0; m_err <= 1'b0; m_halted <= 1'b0;
      m_instr <= '0; m_valid <= 1'b0; m_gap <= 0; m_age <= 0;
    end else if (!m_run) begin
      if (prog_wen) m_prog[prog_addr] <= prog_data;
      if (start) begin
        m_run <= 1'b1; m_pc <= 0; m_cnt <= 0; m_err <= 1'b0; m_halted <= 1'b0; m_gap <= 2;
      end
    end else if (m_gap == 2) begin
      m_word <= m_prog[m_pc];
      if (m_prog[m_pc][W-1 -: 2] == 2'b00) begin
        m_run <= 1'b0; m_halted <= 1'b1;
      end else begin
        m_gap <= 1;
      end
    end else if (m_gap == 1) begin
      m_gap <= 0; m_instr <= m_word; m_valid <= 1'b1; m_age <= 0;
    end else if (instr_done) begin
      m_instr <= '0; m_valid <= 1'b0;
      if (m_cnt < 255) m_cnt <= m_cnt + 1;
      if (m_pc == DEPTH - 1) begin
        m_run <= 1'b0; m_halted <= 1'b1;
      end else begin
        m_pc <= m_pc + 1; m_gap <= 2;
      end
    end else if (m_age == TO - 1) begin
      m_run <= 1'b0; m_halted <= 1'b1; m_err <= 1'b1; m_instr <= '0; m_valid <= 1'b0;
    end else begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_instr", 32'(instr), 32'(m_instr));
      check("m_valid", 32'(instr_valid), 32'(m_valid));
      check("m_pc", 32'(pc), m_pc);
      check("m_busy", 32'(busy), 32'(m_run));
      check("m_halted", 32'(halted), 32'(m_halted));
      check("m_err", 32'(err_timeout), 32'(m_err));
      check("m_count", 32'(issue_count), m_cnt);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input int a, input logic [W-1:0] d);
    prog_addr = PB'(a); prog_data = d; prog_wen = 1'b1;
    tick();
    prog_wen = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 20) begin tick(); n++; end
    if (!instr_valid) check("wait_valid_timeout", 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_halt();
    int n = 0;
    while (!halted && n < 400) begin tick(); n++; end
    if (!halted) check("wait_halt_timeout", 32'(halted), 32'd1);
  endtask

  task automatic ack_run(input int n, input int delay);
    for (int i = 0; i < n; i++) begin
      wait_valid();
      check("instr_word", 32'(instr), 32'(exp_words[i]));
      repeat (delay) tick();
      instr_done = 1'b1;
      tick();
      instr_done = 1'b0;
    end
  endtask

  task automatic set_std();
    exp_words[0] = 20'h5A3C1;
    exp_words[1] = 20'h9B4D2;
    exp_words[2] = 20'hFC5E3;
    for (int i = 0; i < 3; i++) load(i, exp_words[i]);
    load(3, 20'h0);
  endtask

  initial begin
    int n;
    repeat (2) tick();
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // 1: three standard words then a halt word
    set_std();
    start = 1'b1; n = 0;
    do begin tick(); n++; start = 1'b0; end while (!instr_valid && n < 10);
    check("start_latency", n, 3);
    ack_run(3, 2);
    wait_halt();
    check("t1_count", 32'(issue_count), 32'd3);
    check("t1_pc", 32'(pc), 32'd3);
    check("t1_err", 32'(err_timeout), 32'd0);

    // 2: halt word at address 0
    load(0, 20'h0);
    start_run();
    for (int i = 0; i < 4; i++) begin
      check("t2_no_valid", 32'(instr_valid), 32'd0);
      tick();
    end
    check("t2_halted", 32'(halted), 32'd1);
    check("t2_count", 32'(issue_count), 32'd0);

    // 3: watchdog expiry
    load(0, 20'h5A3C1);
    start_run();
    wait_valid();
    n = 0;
    while (!err_timeout && n < 40) begin tick(); n++; end
    check("t3_timeout_cycles", n, TO);
    check("t3_instr", 32'(instr), 32'd0);
    check("t3_count", 32'(issue_count), 32'd0);

    // 4: full store, no wrap
    for (int i = 0; i < DEPTH; i++) begin
      exp_words[i] = 20'h40000 + 20'(i * 'h111);
      load(i, exp_words[i]);
    end
    start_run();
    ack_run(DEPTH, 1);
    wait_halt();
    repeat (3) tick();
    check("t4_pc", 32'(pc), 32'd15);
    check("t4_count", 32'(issue_count), 32'd16);
    check("t4_valid", 32'(instr_valid), 32'd0);

    // 5: write/start ignored mid-run, then reset and rerun
    set_std();
    start_run();
    wait_valid();
    prog_addr = 4'd1; prog_data = 20'hFFFFF; prog_wen = 1'b1; start = 1'b1;
    tick();
    prog_wen = 1'b0; start = 1'b0;
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_instr", 32'(instr), 32'h5A3C1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_instr", 32'(instr), 32'd0);
    check("t5_rst_pc", 32'(pc), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    start_run();
    ack_run(3, 2);
    wait_halt();
    check("t5_count", 32'(issue_count), 32'd3);

    // 6: done on the final watchdog cycle; done while stopped
    load(1, 20'h0);
    start_run();
    wait_valid();
    repeat (TO - 1) tick();
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    check("t6_err", 32'(err_timeout), 32'd0);
    check("t6_count", 32'(issue_count), 32'd1);
    wait_halt();
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    tick();
    check("t6_halt_done", 32'(issue_count), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    tick();
    check("t6_idle_done", 32'(issue_count), 32'd0);
    check("t6_idle_busy", 32'(busy), 32'd0);

    // same-cycle write to address 0 and start
    prog_addr = 4'd0; prog_data = 20'hB1234; prog_wen = 1'b1; start = 1'b1;
    tick();
    prog_wen = 1'b0; start = 1'b0;
    wait_valid();
    check("t6_fwd_word", 32'(instr), 32'hB1234);
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    wait_halt();
    check("t6_fwd_count", 32'(issue_count), 32'd1);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
